// File: rtl/nr_div_pkg.sv
// rtl/nr_div_pkg.sv - shared types and helpers for the Newton-Raphson divider
//
// Contents:
//   state_t  : divider FSM states IDLE..DONE
//   rnd_t    : rounded quotient plus saturation flag
//   seed_k() : smallest k with den <= 2^k (leading-one index, bumped for non-powers of two)
//   sat_q()  : clip an already-rounded quotient to out_w bits
package nr_div_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEED,
        IT_A,
        IT_B,
        MULN,
        RND,
        DONE
    } state_t;

    typedef struct packed {
        logic [31:0] q;
        logic        sat;
    } rnd_t;

    // The highest set bit of den-1, plus one, is the smallest k with den <= 2^k.
    // den == 0 returns 32; the caller never seeds from a zero divisor.
    function automatic logic [5:0] seed_k(input logic [31:0] den);
        logic [31:0] dm1;
        logic [5:0]  k;
        dm1 = den - 32'd1;
        k   = '0;
        for (int i = 0; i < 32; i++) begin
            if (dm1[i]) begin
                k = 6'(i + 1);
            end
        end
        return k;
    endfunction

    function automatic rnd_t sat_q(input logic [127:0] qf, input int out_w);
        rnd_t         r;
        logic [127:0] lim;
        lim = 128'd1 << out_w;
        if (qf >= lim) begin
            r.q   = 32'(lim - 128'd1);
            r.sat = 1'b1;
        end else begin
            r.q   = qf[31:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/nr_mul.sv
// rtl/nr_mul.sv - registered unsigned multiplier, one cycle latency
//
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   a        : A_W-bit unsigned operand
//   b        : B_W-bit unsigned operand
//   p        : registered full-width product a*b
module nr_mul #(
    parameter int A_W = 8,
    parameter int B_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p <= '0;
        end else begin
            p <= (A_W+B_W)'(a) * (A_W+B_W)'(b);
        end
    end

endmodule

// File: rtl/nr_recip_div.sv
// rtl/nr_recip_div.sv - sequential Newton-Raphson divider, q = round(num/den)
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid, in_ready   : operand handshake (in_ready high only in IDLE)
//   num [NUM_W]          : unsigned dividend, NUM_FRAC fractional bits
//   den [DEN_W]          : unsigned divisor, DEN_FRAC fractional bits
//   out_valid, out_ready : result handshake
//   q [OUT_W]            : rounded (half up), saturated quotient, OUT_FRAC fractional bits
//   dz                   : divisor was zero (q all ones)
//   sat                  : quotient clipped to 2^OUT_W-1
module nr_recip_div
    import nr_div_pkg::*;
#(
    parameter int NUM_W    = 27,
    parameter int NUM_FRAC = 12,
    parameter int DEN_W    = 20,
    parameter int DEN_FRAC = 12,
    parameter int ITER     = 4,
    parameter int OUT_W    = 8,
    parameter int OUT_FRAC = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] q,
    output logic             dz,
    output logic             sat
);

    localparam int R   = 2 * DEN_W;
    localparam int SH  = R + NUM_FRAC - DEN_FRAC - OUT_FRAC;
    localparam int X_W = R + 2;
    localparam int A_W = X_W;
    localparam int B_W = (NUM_W > X_W) ? NUM_W : X_W;
    localparam int M_W = A_W + B_W;
    localparam int P_W = NUM_W + R + 1;

    localparam logic [X_W-1:0] T_TWO    = X_W'(1) << (R + 1);
    localparam logic [B_W-1:0] ONE_R    = B_W'(1) << R;
    localparam logic [P_W:0]   HALF     = (P_W + 1)'(1) << (SH - 1);
    localparam logic [3:0]     ITER_END = 4'(ITER - 1);

    if (SH < 1) begin : g_bad_sh
        $error("nr_recip_div: final shift SH must be at least 1");
    end
    if (ITER < 1 || ITER > 8) begin : g_bad_iter
        $error("nr_recip_div: ITER must be within 1..8");
    end
    if (OUT_W < 1 || OUT_W > 31 || DEN_W > 32 || P_W > 127) begin : g_bad_width
        $error("nr_recip_div: unsupported operand or result width");
    end

    state_t           state;
    logic [NUM_W-1:0] num_r;
    logic [DEN_W-1:0] den_r;
    logic [3:0]       cnt;
    logic [X_W-1:0]   x_r;
    logic             dz_pend;

    logic [A_W-1:0]   mul_a;
    logic [B_W-1:0]   mul_b;
    logic [M_W-1:0]   prod;

    logic [5:0]       k;
    logic [X_W-1:0]   x_seed;
    logic [X_W-1:0]   x_cur;
    logic [X_W-1:0]   t_cur;
    logic [P_W:0]     p_sum;
    logic [127:0]     qf;
    rnd_t             rnd;

    // The seed is pushed through the multiplier as x_seed * 2^R, so every
    // state that consumes X takes it from prod >> R, whatever came before.
    always_comb begin
        k      = seed_k(32'(den_r));
        x_seed = X_W'(3) << (R - 1 - int'(k));
        x_cur  = prod[R +: X_W];
        t_cur  = T_TWO - prod[X_W-1:0];
        p_sum  = {1'b0, prod[P_W-1:0]} + HALF;
        qf     = 128'(p_sum >> SH);
        rnd    = sat_q(qf, OUT_W);
    end

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            SEED: begin
                mul_a = x_seed;
                mul_b = ONE_R;
            end
            IT_A: begin
                mul_a = x_cur;
                mul_b = B_W'(den_r);
            end
            IT_B: begin
                mul_a = x_r;
                mul_b = B_W'(t_cur);
            end
            MULN: begin
                mul_a = x_cur;
                mul_b = B_W'(num_r);
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    nr_mul #(
        .A_W (A_W),
        .B_W (B_W)
    ) u_mul (
        .clk (clk),
        .rst (rst),
        .a   (mul_a),
        .b   (mul_b),
        .p   (prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            q         <= '0;
            dz        <= 1'b0;
            sat       <= 1'b0;
            num_r     <= '0;
            den_r     <= '0;
            cnt       <= '0;
            x_r       <= '0;
            dz_pend   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        num_r    <= num;
                        den_r    <= den;
                        cnt      <= '0;
                        dz_pend  <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SEED;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                SEED: begin
                    // A zero divisor borrows the RND slot so its flags and
                    // out_valid update on the same edge as a normal result.
                    if (den_r == '0) begin
                        dz_pend <= 1'b1;
                        state   <= RND;
                    end else begin
                        state   <= IT_A;
                    end
                end
                IT_A: begin
                    x_r   <= x_cur;
                    state <= IT_B;
                end
                IT_B: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == ITER_END) begin
                        state <= MULN;
                    end else begin
                        state <= IT_A;
                    end
                end
                MULN: begin
                    state <= RND;
                end
                RND: begin
                    if (dz_pend) begin
                        q   <= '1;
                        dz  <= 1'b1;
                        sat <= 1'b0;
                    end else begin
                        q   <= rnd.q[OUT_W-1:0];
                        dz  <= 1'b0;
                        sat <= rnd.sat;
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{prod[M_W-1:R+X_W], rnd.q[31:OUT_W]};

endmodule

// File: tb/tb_nr_recip_div.sv
// tb/tb_nr_recip_div.sv - scoreboard bench for nr_recip_div
module tb_nr_recip_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [26:0] num;
    logic [19:0] den;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  q;
    logic        dz;
    logic        sat;

    typedef struct {
        logic [7:0]  q;
        logic        dz;
        logic        sat;
        logic [63:0] exact;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;
    time  last_acc;

    nr_recip_div dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num       (num),
        .den       (den),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .dz        (dz),
        .sat       (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Bit-true reference: seed 3*2^(R-k-1), ITER refinements with T kept to
    // R+2 bits, product with num, round half up, clip to 8 bits.
    function automatic exp_t model(input logic [26:0] n, input logic [19:0] d);
        exp_t         e;
        logic [127:0] x, t, p, f, nn, dd;
        int           k;
        nn      = 128'(n);
        dd      = 128'(d);
        e.exact = (d == 0) ? 64'd0 : 64'((2 * nn + dd) / (2 * dd));
        if (d == 0) begin
            e.q   = 8'hff;
            e.dz  = 1'b1;
            e.sat = 1'b0;
            return e;
        end
        k = 0;
        while ((128'd1 << k) < dd) k++;
        x = 128'd3 << (40 - k - 1);
        for (int i = 0; i < 4; i++) begin
            t = ((128'd1 << 41) - dd * x) & ((128'd1 << 42) - 1);
            x = (x * t) >> 40;
        end
        p = nn * x;
        f = (p + (128'd1 << 39)) >> 40;
        e.dz = 1'b0;
        if (f > 255) begin
            e.q   = 8'hff;
            e.sat = 1'b1;
        end else begin
            e.q   = f[7:0];
            e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic run_op(input logic [26:0] n, input logic [19:0] d, input int exp_lat,
                          input int stall, input int exp_gap);
        exp_t       e;
        int         lat;
        int         w;
        logic       seen;
        logic [7:0] hq;
        logic       hdz;
        logic       hsat;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 50);
        if (!in_ready) begin
            check("in_ready_wait", 64'(in_ready), 64'd1);
            return;
        end
        num      = n;
        den      = d;
        in_valid = 1'b1;
        @(posedge clk);
        if (exp_gap > 0) check("accept_gap", 64'(($time - last_acc) / 10), 64'(exp_gap));
        last_acc = $time;
        sb.push_back(model(n, d));
        #1;
        in_valid = 1'b0;
        num      = 27'($urandom);
        den      = 20'($urandom);
        lat  = 0;
        seen = 1'b0;
        while (lat < 40 && !seen) begin
            @(posedge clk);
            lat++;
            #1 seen = out_valid;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        if (!seen) return;
        hq   = q;
        hdz  = dz;
        hsat = sat;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            check("stall_hold", 64'({out_valid, in_ready, q, dz, sat}),
                  64'({1'b1, 1'b0, hq, hdz, hsat}));
        end
        in_valid = 1'b0;
        if (sb.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb.pop_front();
        check("q", 64'(q), 64'(e.q));
        check("dz", 64'(dz), 64'(e.dz));
        check("sat", 64'(sat), 64'(e.sat));
        if (!e.dz && e.exact < 255) begin
            check("q_within_1", 64'((64'(q) + 1 >= e.exact) && (64'(q) <= e.exact + 1)), 64'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_clear", 64'(out_valid), 64'd0);
        check("in_ready_after", 64'(in_ready), 64'd1);
    endtask

    initial begin
        logic [19:0] rd;
        logic [31:0] hi;
        logic [26:0] rn;
        int          w;
        n_checks  = 0;
        n_errors  = 0;
        last_acc  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        num       = '0;
        den       = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({in_ready, out_valid, q, dz, sat}), 64'd0);
        rst = 1'b0;

        run_op(27'd409600, 20'd16384, 11, 0, 0);
        run_op(27'd20480, 20'd8192, 11, 0, 13);
        run_op(27'd28672, 20'd12288, 11, 0, 13);
        run_op(27'd1228800, 20'd4096, 11, 0, 13);
        run_op(27'd12345, 20'd0, 2, 0, 13);
        run_op(27'd409600, 20'd16384, 11, 5, 0);
        run_op(27'd28672, 20'd12288, 11, 0, 0);

        for (int i = 0; i < 8; i++) begin
            rd = 20'($urandom_range(1, (1 << 20) - 1));
            if (i < 3) rd = 20'($urandom_range(1, 9000));
            hi = 32'(rd) * 32'd300;
            if (hi > 32'h07ff_ffff) hi = 32'h07ff_ffff;
            rn = 27'($urandom_range(0, hi));
            run_op(rn, rd, 11, i % 3, 0);
        end

        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!in_ready && w < 50);
        num      = 27'd409600;
        den      = 20'd16384;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_outputs", 64'({in_ready, out_valid, q, dz, sat}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(27'd409600, 20'd16384, 11, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
